// File: rtl/image_stream_check.sv
// image_stream_check
//   Measures the geometry of a video stream framed by i_vs/i_hs and checks that the active
//   pixel data forms an incrementing ramp. Results for each completed frame are registered
//   and announced with a one-cycle o_frame_done pulse.
//
// Ports
//   i_clk          clock, all logic on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_en           1 = count ramp mismatches; 0 = geometry only
//   i_data         pixel data
//   i_hs           line valid (high during active pixels)
//   i_vs           frame valid (high for the whole frame)
//   o_pix_per_line length of the first line of the last completed frame
//   o_lines        line count of the last completed frame
//   o_err_cnt      ramp mismatches in the last completed frame
//   o_line_err     a line of the last completed frame differed from its first line
//   o_frame_cnt    completed frames since reset (wrapping)
//   o_frame_done   one-cycle pulse while the results above are fresh
module image_stream_check #(
   parameter int unsigned DW = 16,
   parameter int unsigned CW = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_en,
   input  logic [DW-1:0] i_data,
   input  logic          i_hs,
   input  logic          i_vs,
   output logic [CW-1:0] o_pix_per_line,
   output logic [CW-1:0] o_lines,
   output logic [CW-1:0] o_err_cnt,
   output logic          o_line_err,
   output logic [CW-1:0] o_frame_cnt,
   output logic          o_frame_done
);

   typedef enum logic [1:0] {S_SYNC, S_IDLE, S_FRAME, S_DONE} state_t;

   localparam logic [CW-1:0] CntMax = '1;

   state_t        state_q, state_d;
   logic          vs_d, hs_d;

   // Working measurement of the frame in progress
   logic [CW-1:0] run_q, run_d;
   logic [CW-1:0] lines_q, lines_d;
   logic [CW-1:0] ref_q, ref_d;
   logic [CW-1:0] err_q, err_d;
   logic          line_err_q, line_err_d;
   logic [DW-1:0] exp_q, exp_d;
   logic          first_q, first_d;   // next active pixel is the first of the frame

   logic vs_rise, vs_fall, hs_fall;
   logic frame_start, frame_end, active, line_close;

   always_comb begin
      vs_rise     = i_vs & ~vs_d;
      vs_fall     = ~i_vs & vs_d;
      hs_fall     = ~i_hs & hs_d;
      frame_start = vs_rise & ((state_q == S_IDLE) | (state_q == S_DONE));
      frame_end   = vs_fall & (state_q == S_FRAME);
      // The vs_rise cycle already belongs to the frame
      active      = i_vs & i_hs & ((state_q == S_FRAME) | frame_start);
      // A line still open when the frame ends is closed by vs_fall
      line_close  = (state_q == S_FRAME) & (hs_fall | (vs_fall & hs_d));
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_SYNC:  if (!i_vs) state_d = S_IDLE;
         S_IDLE:  if (vs_rise) state_d = S_FRAME;
         S_FRAME: if (vs_fall) state_d = S_DONE;
         S_DONE:  state_d = vs_rise ? S_FRAME : S_IDLE;
         default: state_d = S_SYNC;
      endcase
   end

   always_comb begin
      run_d      = run_q;
      lines_d    = lines_q;
      ref_d      = ref_q;
      err_d      = err_q;
      line_err_d = line_err_q;
      exp_d      = exp_q;
      first_d    = first_q;

      if (frame_start) begin
         run_d      = '0;
         lines_d    = '0;
         ref_d      = '0;
         err_d      = '0;
         line_err_d = 1'b0;
         first_d    = 1'b1;
      end

      if (active) begin
         if (run_d != CntMax) run_d = run_d + CW'(1);
         if (!first_d) begin
            if (i_en && (i_data != exp_q) && (err_d != CntMax)) err_d = err_d + CW'(1);
         end
         // Always resync to the observed value so one bad pixel costs at most two errors
         exp_d   = i_data + DW'(1);
         first_d = 1'b0;
      end

      // Never coincides with active: hs or vs is low on a closing cycle
      if (line_close) begin
         if (lines_q == '0) begin
            ref_d = run_q;
         end else if (run_q != ref_q) begin
            line_err_d = 1'b1;
         end
         if (lines_d != CntMax) lines_d = lines_d + CW'(1);
         run_d = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_SYNC;
         vs_d       <= 1'b0;
         hs_d       <= 1'b0;
         run_q      <= '0;
         lines_q    <= '0;
         ref_q      <= '0;
         err_q      <= '0;
         line_err_q <= 1'b0;
         exp_q      <= '0;
         first_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         vs_d       <= i_vs;
         hs_d       <= i_hs;
         run_q      <= run_d;
         lines_q    <= lines_d;
         ref_q      <= ref_d;
         err_q      <= err_d;
         line_err_q <= line_err_d;
         exp_q      <= exp_d;
         first_q    <= first_d;
      end
   end

   // Results latch the working values including a line closed on the vs_fall cycle itself
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_pix_per_line <= '0;
         o_lines        <= '0;
         o_err_cnt      <= '0;
         o_line_err     <= 1'b0;
         o_frame_cnt    <= '0;
      end else if (frame_end) begin
         o_pix_per_line <= ref_d;
         o_lines        <= lines_d;
         o_err_cnt      <= err_d;
         o_line_err     <= line_err_d;
         o_frame_cnt    <= o_frame_cnt + CW'(1);
      end
   end

   assign o_frame_done = (state_q == S_DONE);

endmodule
